// File: rtl/bit_unstuffer_rx.sv
// bit_unstuffer_rx: removes stuffed zeros from the decoded line stream and assembles LSB-first words
module bit_unstuffer_rx #(
  parameter int STUFF_RUN  = 6,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_enable,
  input  logic                  d_in,
  input  logic                  eop,
  output logic                  d_out,
  output logic                  shift_out,
  output logic [BYTE_WIDTH-1:0] rcv_byte,
  output logic                  byte_ready,
  output logic                  stuff_error
);
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam int CW = $clog2(BYTE_WIDTH + 1);
  typedef enum logic [1:0] {RUN, EXPECT_STUFF, ERROR} state_t;
  state_t state, state_nxt;
  logic [OW-1:0] ones_cnt;
  logic [CW-1:0] bit_cnt;
  logic [BYTE_WIDTH-2:0] sreg;
  logic take, accept, violate, run_full, word_full;
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nxt;
  always_comb
    state_nxt = eop ? RUN :
                !shift_enable ? state :
                (state == RUN) ? ((d_in && run_full) ? EXPECT_STUFF : RUN) :
                (state == EXPECT_STUFF) ? (d_in ? ERROR : RUN) : ERROR;
  always_comb begin
    take      = shift_enable && !eop;
    accept    = take && (state == RUN);
    violate   = take && (state == EXPECT_STUFF) && d_in;
    run_full  = ones_cnt == OW'(STUFF_RUN - 1);
    word_full = bit_cnt == CW'(BYTE_WIDTH - 1);
  end
  // sreg keeps only the newest BYTE_WIDTH-1 bits; the completing bit joins it on the way out
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out       <= 1'b0;
      shift_out   <= 1'b0;
      rcv_byte    <= '0;
      byte_ready  <= 1'b0;
      stuff_error <= 1'b0;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
    end else begin
      shift_out  <= accept;
      byte_ready <= accept && word_full;
      if (accept) d_out <= d_in;
      if (accept && word_full) rcv_byte <= {d_in, sreg};
      if (eop) begin
        ones_cnt    <= '0;
        bit_cnt     <= '0;
        sreg        <= '0;
        stuff_error <= 1'b0;
      end else begin
        if (take) ones_cnt <= (accept && d_in && !run_full) ? ones_cnt + 1'b1 : '0;
        if (accept) begin
          sreg    <= {d_in, sreg[BYTE_WIDTH-2:1]};
          bit_cnt <= word_full ? '0 : bit_cnt + 1'b1;
        end
        if (violate) stuff_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_unstuffer_rx.sv
// tb_bit_unstuffer_rx: scoreboard bench with a bit-queue reference model of the unstuffer
module tb_bit_unstuffer_rx;
  localparam int SR = 6;
  localparam int BW = 8;
  logic clk = 0, rst = 0, shift_enable = 0, d_in = 0, eop = 0;
  logic d_out, shift_out, byte_ready, stuff_error;
  logic [BW-1:0] rcv_byte;
  bit_unstuffer_rx #(.STUFF_RUN(SR), .BYTE_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .d_in(d_in), .eop(eop),
    .d_out(d_out), .shift_out(shift_out), .rcv_byte(rcv_byte),
    .byte_ready(byte_ready), .stuff_error(stuff_error)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; bit d; bit br;} item_t;
  item_t q[$];
  item_t it;
  int tests = 0, fails = 0, cyc_cnt = 0;
  bit mon_en = 0;
  int m_ones = 0;
  bit m_expect = 0, exp_err = 0;
  bit m_word[$];
  logic [BW-1:0] exp_rcv = '0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_cnt, act, exp);
    end
  endfunction
  // Reference: a bit is data unless SR ones in a row just passed; an expected stuff that is 1 kills the packet
  function automatic void model_step(bit d);
    bit br = 0;
    if (exp_err) return;
    if (m_expect) begin
      if (d) exp_err = 1;
      m_expect = 0;
      m_ones = 0;
      return;
    end
    m_word.push_back(d);
    m_ones = d ? m_ones + 1 : 0;
    if (m_ones == SR) begin
      m_expect = 1;
      m_ones = 0;
    end
    if (m_word.size() == BW) begin
      for (int i = 0; i < BW; i++) exp_rcv[i] = m_word[i];
      m_word.delete();
      br = 1;
    end
    q.push_back('{cyc_cnt, d, br});
  endfunction
  function automatic void model_clear(bit full);
    m_ones = 0;
    m_expect = 0;
    exp_err = 0;
    m_word.delete();
    if (full) exp_rcv = '0;
  endfunction
  task automatic drive(bit r, bit se, bit d, bit e);
    @(negedge clk);
    rst = r; shift_enable = se; d_in = d; eop = e;
    @(posedge clk);
    #1;
    if (r) model_clear(1);
    else if (e) model_clear(0);
    else if (se) model_step(d);
    rst = 0; shift_enable = 0; eop = 0;
  endtask
  task automatic send(logic [31:0] bits, int n);
    for (int i = 0; i < n; i++) drive(0, 1, bits[i], 0);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask
  always @(negedge clk) if (mon_en) begin
    while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
      chk("missed_data_bit", 32'(q[0].cyc), 32'(cyc_cnt));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
      it = q.pop_front();
      chk("shift_out", 32'(shift_out), 1);
      chk("d_out", 32'(d_out), 32'(it.d));
      chk("byte_ready", 32'(byte_ready), 32'(it.br));
    end else begin
      chk("shift_out_idle", 32'(shift_out), 0);
      chk("byte_ready_idle", 32'(byte_ready), 0);
    end
    chk("rcv_byte", 32'(rcv_byte), 32'(exp_rcv));
    chk("stuff_error", 32'(stuff_error), 32'(exp_err));
  end
  initial begin
    drive(1, 0, 0, 0);
    chk("reset_d_out", 32'(d_out), 0);
    mon_en = 1;
    idle(2);
    send(32'b110111111, 9);                 // 0xFF with stuff after six ones
    idle(2);
    send(32'b000111111, 9);                 // 0x3F with stuff then two zeros
    idle(2);
    send(32'b1111111, 7);                   // violation on the stuff slot
    send(32'b10110, 5);
    idle(2);
    drive(0, 0, 0, 1);
    send(32'hA5, 8);
    idle(2);
    send(32'b00011111, 8);                  // five ones: nothing removed
    send(32'h00, 8);
    idle(2);
    send(32'b1011, 4);
    drive(0, 1, 1, 1);                      // eop beats coincident strobe
    send(32'hA5, 8);
    idle(2);
    send(32'b111111, 6);                    // now awaiting a stuff bit
    drive(1, 0, 0, 0);
    send(32'h00, 8);
    idle(10);
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      else if (r < 4) drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 20) idle(1);
      else drive(0, 1, m_expect ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0), 0);
    end
    idle(3);
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc_cnt);
    $fatal(1);
  end
endmodule
